bg_checker: RTL

BG_CHECKER -- requirements
Module: bg_checker

---
 rtl/bg_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bg_checker.sv
// Background-pattern memory checker: compares each read word against a pattern
// derived from a 4-bit background code and records mismatch statistics per pass.
module bg_checker #(
    parameter int wlength = 4,
    parameter int alength = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               last,
    input  logic [3:0]         in,
    input  logic               rd_valid,
    input  logic [alength-1:0] rd_addr,
    input  logic [wlength-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               code_err,
    output logic [alength:0]   err_count,
    output logic [alength-1:0] ff_addr,
    output logic [wlength-1:0] ff_data
);

    typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 drain_q, drain_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [alength-1:0]   s1_addr_q, s1_addr_d;
    logic [wlength-1:0]   s1_data_q, s1_data_d;
    logic [wlength-1:0]   s1_exp_q, s1_exp_d;

    logic                 fail_q, fail_d;
    logic                 code_err_q, code_err_d;
    logic [alength:0]     err_count_q, err_count_d;
    logic [alength-1:0]   ff_addr_q, ff_addr_d;
    logic [wlength-1:0]   ff_data_q, ff_data_d;

    logic [3:0]           base_nib;
    logic [3:0]           exp_nib;
    logic [wlength-1:0]   exp_word;
    logic                 code_bad;
    logic                 accept;
    logic                 start_pass;
    logic                 mismatch;

    always_comb begin
        base_nib = 4'b0000;
        case (in[2:1])
            2'b01:   base_nib = 4'b0101;
            2'b10:   base_nib = 4'b0011;
            default: base_nib = 4'b0000;
        endcase
    end

    assign exp_nib    = (in[3] ~^ in[0]) ? ~base_nib : base_nib;
    assign code_bad   = (in[2:1] == 2'b11);

    genvar gi;
    generate
        for (gi = 0; gi < wlength / 4; gi++) begin : g_nib
            assign exp_word[gi*4 +: 4] = exp_nib;
        end
    endgenerate

    assign accept     = (state_q == CHECK) && rd_valid;
    // A start is only honoured between passes; during CHECK/DRAIN it is dropped.
    assign start_pass = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch   = s1_valid_q && (s1_data_q != s1_exp_q);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                if (rd_valid && last) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) state_d = DONE;
                else         drain_d = 1'b1;
            end
            DONE: begin
                if (start) state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: capture the read word together with its expected pattern.
    always_comb begin
        s1_valid_d = accept && !code_bad;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        s1_exp_d   = s1_exp_q;
        if (accept) begin
            s1_addr_d = rd_addr;
            s1_data_d = rd_data;
            s1_exp_d  = exp_word;
        end
    end

    // Stage 2: fold the compare result into the sticky pass statistics.
    always_comb begin
        fail_d      = fail_q;
        code_err_d  = code_err_q;
        err_count_d = err_count_q;
        ff_addr_d   = ff_addr_q;
        ff_data_d   = ff_data_q;
        if (start_pass) begin
            fail_d      = 1'b0;
            code_err_d  = 1'b0;
            err_count_d = '0;
            ff_addr_d   = '0;
            ff_data_d   = '0;
        end else begin
            if (accept && code_bad) code_err_d = 1'b1;
            if (mismatch) begin
                fail_d = 1'b1;
                if (err_count_q != '1)
                    err_count_d = err_count_q + {{alength{1'b0}}, 1'b1};
                // fail_q is still low only for the first mismatch of the pass.
                if (!fail_q) begin
                    ff_addr_d = s1_addr_q;
                    ff_data_d = s1_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_exp_q    <= '0;
            fail_q      <= 1'b0;
            code_err_q  <= 1'b0;
            err_count_q <= '0;
            ff_addr_q   <= '0;
            ff_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_exp_q    <= s1_exp_d;
            fail_q      <= fail_d;
            code_err_q  <= code_err_d;
            err_count_q <= err_count_d;
            ff_addr_q   <= ff_addr_d;
            ff_data_q   <= ff_data_d;
        end
    end

    assign busy      = (state_q == CHECK) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign fail      = fail_q;
    assign code_err  = code_err_q;
    assign err_count = err_count_q;
    assign ff_addr   = ff_addr_q;
    assign ff_data   = ff_data_q;

endmodule
